// File: rtl/inst_fetch_req_way0_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared width constant, reset PC and buffer entry type for the
//            way-0 fetch-request path.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic            filled;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_req_way0_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_req_way0_if
// Brief    : Redirect, instruction-memory and fetch-unit handshake bundle.
// Revision : 1.0
// ============================================================================
interface inst_fetch_req_way0_if;
    import fetch_pkg::*;

    logic            jumpFlag_i;
    logic [XLEN-1:0] jumpAddr_i;
    logic            request_o;
    logic [XLEN-1:0] instAddr_fetch_o;
    logic            req_ready_i;
    logic            resp_valid_i;
    logic [XLEN-1:0] resp_data_i;
    logic            valid_o;
    logic [XLEN-1:0] inst_o;
    logic [XLEN-1:0] instAddr_o;
    logic            ready_i;

    modport master (
        input  jumpFlag_i, jumpAddr_i, req_ready_i, resp_valid_i, resp_data_i, ready_i,
        output request_o, instAddr_fetch_o, valid_o, inst_o, instAddr_o
    );

    modport slave (
        output jumpFlag_i, jumpAddr_i, req_ready_i, resp_valid_i, resp_data_i, ready_i,
        input  request_o, instAddr_fetch_o, valid_o, inst_o, instAddr_o
    );

endinterface
`default_nettype wire

// File: rtl/inst_fetch_req_way0_entry_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_entry_buffer
// Brief    : DEPTH-slot in-order fetch buffer with alloc/fill/read pointers
//            and a flush that discards every entry.
// Revision : 1.0
// ============================================================================
module fetch_entry_buffer
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    input  wire logic            flush_i,
    input  wire logic            alloc_i,
    input  wire logic [XLEN-1:0] alloc_addr_i,
    input  wire logic            fill_i,
    input  wire logic [XLEN-1:0] fill_data_i,
    input  wire logic            pop_i,
    output fetch_entry_t         head_o,
    output logic [CNT_W-1:0]     occupancy_o,
    output logic [CNT_W-1:0]     inflight_o
);

    fetch_entry_t      slots_q [DEPTH];
    logic [PTR_W-1:0]  alloc_ptr_q;
    logic [PTR_W-1:0]  fill_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  occupancy_q;
    logic [CNT_W-1:0]  inflight_q;

    // Alloc, fill and pop always address distinct slots: alloc targets a free
    // slot, fill an allocated-unfilled one, pop a filled one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= '0;
            end
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            rd_ptr_q    <= '0;
            occupancy_q <= '0;
            inflight_q  <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i].filled <= 1'b0;
            end
            fill_ptr_q  <= alloc_ptr_q;
            rd_ptr_q    <= alloc_ptr_q;
            occupancy_q <= '0;
            inflight_q  <= '0;
        end else begin
            if (alloc_i) begin
                slots_q[alloc_ptr_q].addr   <= alloc_addr_i;
                slots_q[alloc_ptr_q].filled <= 1'b0;
                alloc_ptr_q                 <= alloc_ptr_q + 1'b1;
            end
            if (fill_i) begin
                slots_q[fill_ptr_q].data   <= fill_data_i;
                slots_q[fill_ptr_q].filled <= 1'b1;
                fill_ptr_q                 <= fill_ptr_q + 1'b1;
            end
            if (pop_i) begin
                slots_q[rd_ptr_q].filled <= 1'b0;
                rd_ptr_q                 <= rd_ptr_q + 1'b1;
            end
            occupancy_q <= occupancy_q + CNT_W'(alloc_i) - CNT_W'(pop_i);
            inflight_q  <= inflight_q + CNT_W'(alloc_i) - CNT_W'(fill_i);
        end
    end

    assign head_o      = slots_q[rd_ptr_q];
    assign occupancy_o = occupancy_q;
    assign inflight_o  = inflight_q;

endmodule
`default_nettype wire

// File: rtl/inst_fetch_req_way0.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_req_way0
// Brief    : Way-0 fetch-request generator: owns the PC, issues memory
//            requests, buffers in-order responses and drops stale ones after
//            a jump. Optional perf counters: define FETCH_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
module inst_fetch_req_way0
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    inst_fetch_req_way0_if.master   bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]             perf_issued_o,
    output logic [31:0]             perf_dropped_o,
    output logic [31:0]             perf_stall_o
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W:0]   credits_used;
    fetch_entry_t     head;
    logic             fire;
    logic             resp_drop;
    logic             fill;
    logic             deliver;

    // Stale responses still owed by memory consume credits just like live entries.
    assign credits_used = {1'b0, occupancy} + {1'b0, drop_cnt_q};

    assign bus.request_o        = reset_n & ~bus.jumpFlag_i & (credits_used < (CNT_W + 1)'(DEPTH));
    assign bus.instAddr_fetch_o = pc_q;
    assign fire                 = bus.request_o & bus.req_ready_i;

    assign resp_drop = bus.resp_valid_i & (drop_cnt_q != '0);
    assign fill      = bus.resp_valid_i & (drop_cnt_q == '0) & ~bus.jumpFlag_i;

    assign bus.valid_o    = head.filled & (occupancy != '0) & ~bus.jumpFlag_i;
    assign bus.inst_o     = head.data;
    assign bus.instAddr_o = head.addr;
    assign deliver        = bus.valid_o & bus.ready_i;

    always_comb begin
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.jumpFlag_i) begin
            pc_d       = bus.jumpAddr_i;
            drop_cnt_d = drop_cnt_q + inflight - CNT_W'(bus.resp_valid_i);
        end else begin
            if (fire) begin
                pc_d = pc_q + PC_STEP;
            end
            drop_cnt_d = drop_cnt_q - CNT_W'(resp_drop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_entry_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush_i      (bus.jumpFlag_i),
        .alloc_i      (fire),
        .alloc_addr_i (pc_q),
        .fill_i       (fill),
        .fill_data_i  (bus.resp_data_i),
        .pop_i        (deliver),
        .head_o       (head),
        .occupancy_o  (occupancy),
        .inflight_o   (inflight)
    );

    a_resp_expected: assert property (@(posedge clk) disable iff (!reset_n)
        bus.resp_valid_i |-> ((drop_cnt_q != '0) || (inflight != '0)));

    a_credit_bound: assert property (@(posedge clk) disable iff (!reset_n)
        credits_used <= (CNT_W + 1)'(DEPTH));

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_issued_q;
    logic [31:0] perf_dropped_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_issued_q  <= '0;
            perf_dropped_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (fire && (perf_issued_q != '1)) begin
                perf_issued_q <= perf_issued_q + 1'b1;
            end
            if (bus.resp_valid_i && ((drop_cnt_q != '0) || bus.jumpFlag_i) && (perf_dropped_q != '1)) begin
                perf_dropped_q <= perf_dropped_q + 1'b1;
            end
            if (bus.valid_o && !bus.ready_i && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 1'b1;
            end
        end
    end

    assign perf_issued_o  = perf_issued_q;
    assign perf_dropped_o = perf_dropped_q;
    assign perf_stall_o   = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_req_way0.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_req_way0
// Brief    : Vector table, directed corner sequences and random traffic against
//            an epoch-based fetch model with an in-order memory model.
// Revision : 1.0
// ============================================================================
module tb_inst_fetch_req_way0;
    import fetch_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h8000_0000;

    logic clk = 1'b0;
    logic reset_n;

    inst_fetch_req_way0_if bus();

    inst_fetch_req_way0 #(
        .RESET_PC (RPC),
        .DEPTH    (DEPTH),
        .PC_STEP  (32'd4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        jump;
        logic [31:0] jaddr;
        logic        rv;
        logic [31:0] rd;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_faddr;
        logic        e_valid;
        logic [31:0] e_iaddr;
    } vec_t;

    function automatic vec_t v(input logic jump, input logic [31:0] jaddr, input logic rv,
                               input logic [31:0] rd, input logic rdy, input logic e_req,
                               input logic [31:0] e_faddr, input logic e_valid,
                               input logic [31:0] e_iaddr);
        vec_t r;
        r.jump = jump; r.jaddr = jaddr; r.rv = rv; r.rd = rd; r.rdy = rdy;
        r.e_req = e_req; r.e_faddr = e_faddr; r.e_valid = e_valid; r.e_iaddr = e_iaddr;
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
    typedef struct { logic [31:0] addr; logic got; } cent_t;

    mreq_t       mq[$];
    cent_t       cq[$];
    int          epoch  = 0;
    int          cyc    = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    logic [31:0] pc_m;
    int          seen100;
    int          seen200;

    task automatic drive_idle();
        bus.jumpFlag_i   = 1'b0;
        bus.jumpAddr_i   = '0;
        bus.req_ready_i  = 1'b0;
        bus.resp_valid_i = 1'b0;
        bus.resp_data_i  = '0;
        bus.ready_i      = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " request_o"},        bus.request_o,        32'd0);
        chk({tag, " instAddr_fetch_o"}, bus.instAddr_fetch_o, RPC);
        chk({tag, " valid_o"},          bus.valid_o,          32'd0);
        chk({tag, " inst_o"},           bus.inst_o,           32'd0);
        chk({tag, " instAddr_o"},       bus.instAddr_o,       32'd0);
    endtask

    task automatic model_clear();
        mq.delete();
        cq.delete();
        epoch++;
        pc_m = RPC;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        model_clear();
        reset_n = 1'b1;
    endtask

    // One cycle: drive at the falling edge, compare, advance the model, clock.
    task automatic mstep(input logic jmp, input logic [31:0] ja, input logic rdy, input logic rreq);
        logic        rv;
        logic [31:0] rd;
        int          stale;
        logic        e_req;
        logic        e_valid;
        logic        done;
        rv = (mq.size() > 0) && (mq[0].due <= cyc);
        rd = rv ? dat(mq[0].addr) : 32'h0;
        bus.jumpFlag_i   = jmp;
        bus.jumpAddr_i   = ja;
        bus.ready_i      = rdy;
        bus.req_ready_i  = rreq;
        bus.resp_valid_i = rv;
        bus.resp_data_i  = rd;
        #1;
        stale = 0;
        foreach (mq[i]) if (mq[i].epoch != epoch) stale++;
        e_req   = !jmp && ((cq.size() + stale) < DEPTH);
        e_valid = !jmp && (cq.size() > 0) && cq[0].got;
        chk("request_o", bus.request_o, e_req);
        chk("instAddr_fetch_o", bus.instAddr_fetch_o, pc_m);
        chk("valid_o", bus.valid_o, e_valid);
        if (e_valid && bus.valid_o) begin
            chk("instAddr_o", bus.instAddr_o, cq[0].addr);
            chk("inst_o", bus.inst_o, dat(cq[0].addr));
        end
        if (bus.valid_o && rdy) begin
            if (bus.instAddr_o >= 32'h100 && bus.instAddr_o < 32'h200) seen100++;
            if (bus.instAddr_o >= 32'h200 && bus.instAddr_o < 32'h300) seen200++;
        end
        if (rv) begin
            if (mq[0].epoch == epoch) begin
                done = 1'b0;
                for (int i = 0; i < cq.size(); i++) begin
                    if (!done && !cq[i].got) begin
                        cq[i].got = 1'b1;
                        done = 1'b1;
                    end
                end
            end
            void'(mq.pop_front());
        end
        if (jmp) begin
            cq.delete();
            epoch++;
            pc_m = ja;
        end else begin
            if (e_valid && rdy) void'(cq.pop_front());
            if (e_req && rreq) begin
                cq.push_back('{addr: pc_m, got: 1'b0});
                mq.push_back('{addr: pc_m, epoch: epoch, due: cyc + $urandom_range(lat_hi, lat_lo)});
                pc_m = pc_m + 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[19];
        logic [31:0] A;
        logic [31:0] B;
        int          waited;

        A = RPC;
        B = 32'h8000_1000;
        //          jump  jaddr rv    rd             rdy   req   faddr      valid iaddr
        vt[0]  = v(1'b0, '0,   1'b0, '0,            1'b1, 1'b1, A,         1'b0, '0);
        vt[1]  = v(1'b0, '0,   1'b1, dat(A),        1'b1, 1'b1, A+32'h04,  1'b0, '0);
        vt[2]  = v(1'b0, '0,   1'b1, dat(A+32'h04), 1'b1, 1'b0, A+32'h08,  1'b1, A);
        vt[3]  = v(1'b0, '0,   1'b0, '0,            1'b1, 1'b1, A+32'h08,  1'b1, A+32'h04);
        vt[4]  = v(1'b0, '0,   1'b1, dat(A+32'h08), 1'b1, 1'b1, A+32'h0C,  1'b0, '0);
        vt[5]  = v(1'b0, '0,   1'b1, dat(A+32'h0C), 1'b1, 1'b0, A+32'h10,  1'b1, A+32'h08);
        vt[6]  = v(1'b0, '0,   1'b0, '0,            1'b1, 1'b1, A+32'h10,  1'b1, A+32'h0C);
        vt[7]  = v(1'b0, '0,   1'b1, dat(A+32'h10), 1'b0, 1'b1, A+32'h14,  1'b0, '0);
        vt[8]  = v(1'b0, '0,   1'b1, dat(A+32'h14), 1'b0, 1'b0, A+32'h18,  1'b1, A+32'h10);
        vt[9]  = v(1'b0, '0,   1'b0, '0,            1'b0, 1'b0, A+32'h18,  1'b1, A+32'h10);
        vt[10] = v(1'b0, '0,   1'b0, '0,            1'b1, 1'b0, A+32'h18,  1'b1, A+32'h10);
        vt[11] = v(1'b0, '0,   1'b0, '0,            1'b1, 1'b1, A+32'h18,  1'b1, A+32'h14);
        vt[12] = v(1'b0, '0,   1'b0, '0,            1'b1, 1'b1, A+32'h1C,  1'b0, '0);
        vt[13] = v(1'b1, B,    1'b0, '0,            1'b1, 1'b0, A+32'h20,  1'b0, '0);
        vt[14] = v(1'b0, '0,   1'b1, dat(A+32'h18), 1'b1, 1'b0, B,         1'b0, '0);
        vt[15] = v(1'b0, '0,   1'b1, dat(A+32'h1C), 1'b1, 1'b1, B,         1'b0, '0);
        vt[16] = v(1'b0, '0,   1'b1, dat(B),        1'b1, 1'b1, B+32'h04,  1'b0, '0);
        vt[17] = v(1'b0, '0,   1'b0, '0,            1'b1, 1'b0, B+32'h08,  1'b1, B);
        vt[18] = v(1'b0, '0,   1'b1, dat(B+32'h04), 1'b1, 1'b1, B+32'h08,  1'b0, '0);

        drive_idle();
        do_reset();

        for (int i = 0; i < 19; i++) begin
            bus.jumpFlag_i   = vt[i].jump;
            bus.jumpAddr_i   = vt[i].jaddr;
            bus.req_ready_i  = 1'b1;
            bus.resp_valid_i = vt[i].rv;
            bus.resp_data_i  = vt[i].rd;
            bus.ready_i      = vt[i].rdy;
            #1;
            chk($sformatf("vec%0d request_o", i), bus.request_o, vt[i].e_req);
            chk($sformatf("vec%0d instAddr_fetch_o", i), bus.instAddr_fetch_o, vt[i].e_faddr);
            chk($sformatf("vec%0d valid_o", i), bus.valid_o, vt[i].e_valid);
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d instAddr_o", i), bus.instAddr_o, vt[i].e_iaddr);
                chk($sformatf("vec%0d inst_o", i), bus.inst_o, dat(vt[i].e_iaddr));
            end
            @(posedge clk);
            @(negedge clk);
        end

        // Jump in the same cycle as a response with two requests in flight.
        do_reset();
        lat_lo = 2; lat_hi = 2;
        mstep(1'b0, '0, 1'b1, 1'b1);
        mstep(1'b0, '0, 1'b1, 1'b1);
        chk("two in flight before jump", 32'(cq.size()), 32'd2);
        mstep(1'b1, 32'h8000_2000, 1'b1, 1'b1);
        chk("one stale response owed", 32'(mq.size()), 32'd1);
        repeat (8) mstep(1'b0, '0, 1'b1, 1'b1);

        // Back-to-back jumps: only the second target's stream may appear.
        do_reset();
        lat_lo = 1; lat_hi = 3;
        seen100 = 0; seen200 = 0;
        mstep(1'b0, '0, 1'b1, 1'b1);
        mstep(1'b0, '0, 1'b1, 1'b1);
        mstep(1'b1, 32'h100, 1'b1, 1'b1);
        mstep(1'b1, 32'h200, 1'b1, 1'b1);
        repeat (14) mstep(1'b0, '0, 1'b1, 1'b1);
        chk("deliveries from 0x100 stream", 32'(seen100), 32'd0);
        chk("0x200 stream delivered", 32'(seen200 > 0), 32'd1);

        // Asynchronous reset with a full buffer.
        do_reset();
        lat_lo = 1; lat_hi = 1;
        waited = 0;
        while (!(cq.size() == DEPTH && cq[0].got && cq[1].got) && waited < 20) begin
            mstep(1'b0, '0, 1'b0, 1'b1);
            waited++;
        end
        chk("buffer filled before reset", 32'(waited < 20), 32'd1);
        #2;
        reset_n = 1'b0;
        drive_idle();
        #1;
        chk_reset_outputs("async reset");
        @(posedge clk);
        #1;
        chk_reset_outputs("held reset");
        @(negedge clk);
        model_clear();
        reset_n = 1'b1;
        repeat (6) mstep(1'b0, '0, 1'b1, 1'b1);

        // Random traffic against the model.
        do_reset();
        lat_lo = 1; lat_hi = 3;
        for (int i = 0; i < 400; i++) begin
            mstep(($urandom_range(15, 0) == 0), {$urandom} & 32'hFFFF_FFFC,
                  ($urandom_range(9, 0) < 7), ($urandom_range(3, 0) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
